// File: rtl/dnn_buf_pkg.sv
// Shared types and arithmetic helpers for the ping-pong buffer.
package dnn_buf_pkg;

  // Index of one of the two banks.
  typedef logic bank_t;

  // Widest data word the adder helper supports.
  localparam int MAX_DW = 64;

  // Two's-complement add of two dw-bit words held in the low bits of a and b.
  // The sum is returned in the low dw bits. When sat is set, the result is
  // clamped to the signed dw-bit range; otherwise it wraps modulo 2^dw.
  function automatic logic [MAX_DW-1:0] sat_add(input logic [MAX_DW-1:0] a,
                                                input logic [MAX_DW-1:0] b,
                                                input int dw,
                                                input logic sat);
    int sh;
    logic signed [MAX_DW-1:0] ta;
    logic signed [MAX_DW-1:0] tb;
    logic signed [MAX_DW:0]   sum;
    logic signed [MAX_DW:0]   hi;
    logic signed [MAX_DW:0]   lo;
    sh  = MAX_DW - dw;
    ta  = $signed(a << sh) >>> sh;
    tb  = $signed(b << sh) >>> sh;
    sum = {ta[MAX_DW-1], ta} + {tb[MAX_DW-1], tb};
    hi  = (($signed({{MAX_DW{1'b0}}, 1'b1})) <<< (dw - 1)) - 1;
    lo  = -(($signed({{MAX_DW{1'b0}}, 1'b1})) <<< (dw - 1));
    if (sat && (sum > hi)) begin
      sum = hi;
    end else if (sat && (sum < lo)) begin
      sum = lo;
    end
    return sum[MAX_DW-1:0];
  endfunction

endpackage

// File: rtl/dnn_buf_bank.sv
// One bank of the ping-pong buffer: write port, registered read port and a
// combinational read port used for read-modify-write operand fetch.
module dnn_buf_bank
  import dnn_buf_pkg::*;
#(
  parameter int DW = 32,
  parameter int AW = 12
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata,
  input  logic [AW-1:0] aaddr,
  output logic [DW-1:0] adata
);

  logic [DW-1:0] mem [2**AW];

  // Storage array write; contents are never reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Registered read; returns pre-write data on a same-address collision.
  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
  end

  assign adata = mem[aaddr];

endmodule

// File: rtl/dnn_pingpong_buf.sv
// Two-bank ping-pong buffer between the host load/unload path and the MAC
// core. Core writes pass through one registered stage with accumulate and
// forwarding into both the next accumulate and core reads.
module dnn_pingpong_buf
  import dnn_buf_pkg::*;
#(
  parameter int DW  = 32,
  parameter int AW  = 12,
  parameter int SAT = 0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          h_wr,
  input  logic          h_rd,
  input  logic [AW-1:0] h_addr,
  input  logic [DW-1:0] h_wdata,
  output logic [DW-1:0] h_rdata,
  output logic          h_rvalid,
  input  logic          c_rd,
  input  logic [AW-1:0] c_raddr,
  output logic [DW-1:0] c_rdata,
  output logic          c_rvalid,
  input  logic          c_wr,
  input  logic          c_acc,
  input  logic [AW-1:0] c_waddr,
  input  logic [DW-1:0] c_wdata,
  input  logic          swap,
  output logic          host_bank
);

  function automatic logic [DW-1:0] acc_add(input logic [DW-1:0] a,
                                            input logic [DW-1:0] b);
    return DW'(sat_add(MAX_DW'(a), MAX_DW'(b), DW, (SAT != 0)));
  endfunction

  bank_t         core_bank;
  logic [DW-1:0] bank_rdata [2];
  logic [DW-1:0] bank_adata [2];

  logic          wr_vld_p1;
  bank_t         wr_bank_p1;
  logic [AW-1:0] wr_addr_p1;
  logic [DW-1:0] wr_data_p1;
  logic [DW-1:0] wr_old_p1;
  logic          wr_acc_p1;
  logic [DW-1:0] commit_val;
  logic [DW-1:0] old_p0;
  logic          wr_fwd;
  logic          rd_fwd;

  bank_t         h_sel_p1;
  bank_t         c_sel_p1;
  logic          c_fwd_p1;
  logic [DW-1:0] c_fwd_data_p1;
  logic [DW-1:0] h_hold;
  logic [DW-1:0] c_hold;

  assign core_bank  = ~host_bank;
  assign commit_val = wr_acc_p1 ? acc_add(wr_old_p1, wr_data_p1) : wr_data_p1;

  // A write still in the stage to the same bank/address supplies the newest value.
  assign wr_fwd = wr_vld_p1 && (wr_bank_p1 == core_bank) && (wr_addr_p1 == c_waddr);
  assign rd_fwd = wr_vld_p1 && (wr_bank_p1 == core_bank) && (wr_addr_p1 == c_raddr);
  assign old_p0 = wr_fwd ? commit_val : bank_adata[core_bank];

  for (genvar b = 0; b < 2; b++) begin : g_bank
    localparam bank_t ID = bank_t'(b);
    logic          own;
    logic          commit;
    logic          bwe;
    logic [AW-1:0] bwaddr;
    logic [DW-1:0] bwdata;
    assign own    = (host_bank == ID);
    assign commit = wr_vld_p1 && (wr_bank_p1 == ID);
    // A late commit into a bank the host now owns takes priority over a host write.
    assign bwe    = commit || (own && h_wr);
    assign bwaddr = commit ? wr_addr_p1 : h_addr;
    assign bwdata = commit ? commit_val : h_wdata;

    dnn_buf_bank #(.DW(DW), .AW(AW)) u_bank (
      .clk   (clk),
      .we    (bwe),
      .waddr (bwaddr),
      .wdata (bwdata),
      .re    (own ? h_rd : c_rd),
      .raddr (own ? h_addr : c_raddr),
      .rdata (bank_rdata[b]),
      .aaddr (c_waddr),
      .adata (bank_adata[b])
    );
  end

  // Bank ownership; swap toggles it at the edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) host_bank <= 1'b0;
    else if (swap) host_bank <= ~host_bank;
  end

  // Stage p0 -> p1: write-stage and read-valid control.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_vld_p1 <= 1'b0;
      h_rvalid  <= 1'b0;
      c_rvalid  <= 1'b0;
    end else begin
      wr_vld_p1 <= c_wr;
      h_rvalid  <= h_rd;
      c_rvalid  <= c_rd;
    end
  end

  // Stage p0 -> p1: write-stage payload and read-side selects.
  always_ff @(posedge clk) begin
    if (c_wr) begin
      wr_bank_p1 <= core_bank;
      wr_addr_p1 <= c_waddr;
      wr_data_p1 <= c_wdata;
      wr_old_p1  <= old_p0;
      wr_acc_p1  <= c_acc;
    end
    if (h_rd) h_sel_p1 <= host_bank;
    if (c_rd) begin
      c_sel_p1      <= core_bank;
      c_fwd_p1      <= rd_fwd;
      c_fwd_data_p1 <= commit_val;
    end
  end

  // Output hold registers keep the last read data between strobes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_hold <= '0;
      c_hold <= '0;
    end else begin
      h_hold <= h_rdata;
      c_hold <= c_rdata;
    end
  end

  assign h_rdata = h_rvalid ? bank_rdata[h_sel_p1] : h_hold;
  assign c_rdata = c_rvalid ? (c_fwd_p1 ? c_fwd_data_p1 : bank_rdata[c_sel_p1]) : c_hold;

endmodule

// File: tb/tb_dnn_pingpong_buf.sv
// Directed bench for dnn_pingpong_buf: a wrapping and a saturating instance
// (DW=16) share one stimulus stream.
module tb_dnn_pingpong_buf;

  localparam int DW = 16;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          h_wr, h_rd;
  logic [AW-1:0] h_addr;
  logic [DW-1:0] h_wdata;
  logic          c_rd, c_wr, c_acc;
  logic [AW-1:0] c_raddr, c_waddr;
  logic [DW-1:0] c_wdata;
  logic          swap;

  logic [DW-1:0] w_h_rdata, w_c_rdata, s_h_rdata, s_c_rdata;
  logic          w_h_rvalid, w_c_rvalid, s_h_rvalid, s_c_rvalid;
  logic          w_host_bank, s_host_bank;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dnn_pingpong_buf #(.DW(DW), .AW(AW), .SAT(0)) u_wrap (
    .clk(clk), .reset(reset),
    .h_wr(h_wr), .h_rd(h_rd), .h_addr(h_addr), .h_wdata(h_wdata),
    .h_rdata(w_h_rdata), .h_rvalid(w_h_rvalid),
    .c_rd(c_rd), .c_raddr(c_raddr), .c_rdata(w_c_rdata), .c_rvalid(w_c_rvalid),
    .c_wr(c_wr), .c_acc(c_acc), .c_waddr(c_waddr), .c_wdata(c_wdata),
    .swap(swap), .host_bank(w_host_bank)
  );

  dnn_pingpong_buf #(.DW(DW), .AW(AW), .SAT(1)) u_sat (
    .clk(clk), .reset(reset),
    .h_wr(h_wr), .h_rd(h_rd), .h_addr(h_addr), .h_wdata(h_wdata),
    .h_rdata(s_h_rdata), .h_rvalid(s_h_rvalid),
    .c_rd(c_rd), .c_raddr(c_raddr), .c_rdata(s_c_rdata), .c_rvalid(s_c_rvalid),
    .c_wr(c_wr), .c_acc(c_acc), .c_waddr(c_waddr), .c_wdata(c_wdata),
    .swap(swap), .host_bank(s_host_bank)
  );

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    h_wr = 0; h_rd = 0; c_rd = 0; c_wr = 0; c_acc = 0; swap = 0;
  endtask

  task automatic host_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    h_wr = 1; h_addr = a; h_wdata = d;
    tick();
    h_wr = 0;
  endtask

  initial begin
    reset = 1; idle();
    h_addr = '0; h_wdata = '0; c_raddr = '0; c_waddr = '0; c_wdata = '0;
    tick(); tick();
    chk("rst_h_rvalid", w_h_rvalid, 0);
    chk("rst_c_rvalid", w_c_rvalid, 0);
    chk("rst_h_rdata", w_h_rdata, 0);
    chk("rst_c_rdata", s_c_rdata, 0);
    chk("rst_host_bank", w_host_bank, 0);
    reset = 0;
    tick();

    // Host fills bank 0.
    host_write(8'd5, 16'h0011);
    host_write(8'd3, 16'h1234);
    host_write(8'd9, 16'h7FF0);
    host_write(8'd7, 16'h00AA);
    host_write(8'd13, 16'h0101);

    h_rd = 1; h_addr = 8'd5;
    tick(); h_rd = 0;
    chk("h_rd_valid", w_h_rvalid, 1);
    chk("h_rd_data", w_h_rdata, 16'h0011);
    tick();
    chk("h_rvalid_pulse", w_h_rvalid, 0);
    chk("h_rdata_hold", w_h_rdata, 16'h0011);
    chk("host_bank_0", w_host_bank, 0);

    // Same-cycle write and read: read returns old data.
    h_wr = 1; h_rd = 1; h_addr = 8'd7; h_wdata = 16'h00BB;
    tick(); h_wr = 0; h_rd = 0;
    chk("h_rw_old", w_h_rdata, 16'h00AA);
    h_rd = 1;
    tick(); h_rd = 0;
    chk("h_rw_new", w_h_rdata, 16'h00BB);

    // Swap: core now owns bank 0.
    swap = 1;
    tick(); swap = 0;
    chk("host_bank_1", w_host_bank, 1);

    c_rd = 1; c_raddr = 8'd5;
    tick(); c_rd = 0;
    chk("c_rd_valid", w_c_rvalid, 1);
    chk("c_rd_data", w_c_rdata, 16'h0011);

    // Three back-to-back accumulates of 0x22 onto 0x11.
    c_wr = 1; c_acc = 1; c_waddr = 8'd5; c_wdata = 16'h0022;
    tick(); tick(); tick();
    c_wr = 0; c_acc = 0;
    c_rd = 1; c_raddr = 8'd5;
    tick(); c_rd = 0;
    chk("acc_chain_fwd", w_c_rdata, 16'h0077);
    c_rd = 1;
    tick(); c_rd = 0;
    chk("acc_chain_mem", s_c_rdata, 16'h0077);

    // Overwrite with same-cycle read (old) then next-cycle read (forwarded).
    c_wr = 1; c_acc = 0; c_waddr = 8'd3; c_wdata = 16'h0005;
    c_rd = 1; c_raddr = 8'd3;
    tick(); c_wr = 0;
    chk("ovw_same_cycle_old", w_c_rdata, 16'h1234);
    tick(); c_rd = 0;
    chk("ovw_next_cycle_fwd", w_c_rdata, 16'h0005);

    // Positive overflow: 0x7FF0 + 0x0100.
    c_wr = 1; c_acc = 1; c_waddr = 8'd9; c_wdata = 16'h0100;
    tick(); c_wr = 0; c_acc = 0;
    c_rd = 1; c_raddr = 8'd9;
    tick(); c_rd = 0;
    chk("sat_pos", s_c_rdata, 16'h7FFF);
    chk("wrap_pos", w_c_rdata, 16'h80F0);

    // Negative overflow: 0x8010 + 0xFF00 (-256).
    c_wr = 1; c_acc = 0; c_waddr = 8'd10; c_wdata = 16'h8010;
    tick();
    c_acc = 1; c_wdata = 16'hFF00;
    tick(); c_wr = 0; c_acc = 0;
    c_rd = 1; c_raddr = 8'd10;
    tick(); c_rd = 0;
    chk("sat_neg", s_c_rdata, 16'h8000);
    chk("wrap_neg", w_c_rdata, 16'h7F10);

    // Core write in the swap cycle lands in the old core bank (bank 0).
    c_wr = 1; c_acc = 0; c_waddr = 8'd12; c_wdata = 16'h4321; swap = 1;
    tick(); c_wr = 0; swap = 0;
    chk("host_bank_back_0", w_host_bank, 0);
    tick();
    h_rd = 1; h_addr = 8'd12;
    tick(); h_rd = 0;
    chk("swap_cycle_wr", w_h_rdata, 16'h4321);

    // Reset with a pending commit to bank 0 address 13.
    swap = 1;
    tick(); swap = 0;
    chk("host_bank_1_again", s_host_bank, 1);
    c_wr = 1; c_acc = 0; c_waddr = 8'd13; c_wdata = 16'h7777;
    c_rd = 1; c_raddr = 8'd5;
    tick(); c_wr = 0; c_rd = 0;
    chk("pre_rst_c_rdata", w_c_rdata, 16'h0077);
    reset = 1;
    tick();
    chk("mid_rst_h_rdata", w_h_rdata, 0);
    chk("mid_rst_c_rdata", w_c_rdata, 0);
    chk("mid_rst_h_rvalid", s_h_rvalid, 0);
    chk("mid_rst_c_rvalid", s_c_rvalid, 0);
    chk("mid_rst_host_bank", w_host_bank, 0);
    reset = 0;
    tick();
    h_rd = 1; h_addr = 8'd13;
    tick(); h_rd = 0;
    chk("rst_drops_commit", w_h_rdata, 16'h0101);
    chk("rst_drops_commit_sat", s_h_rdata, 16'h0101);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dnn_pingpong_buf.md
# dnn_pingpong_buf

Parametrised two-bank ping-pong buffer that sits between the host load/unload path and the MAC core of the MNIST accelerator. It generalises the separate source and destination buffers into one block. The host fills or drains one bank while the core reads operands from, and writes or accumulates results into, the other bank. A `swap` pulse exchanges the banks. Core writes go through a registered write stage with read-modify-write accumulate, optional saturation, and full forwarding.

## Interface
Parameters:
- `DW`, 32: data word width.
- `AW`, 12: address width; each bank holds 2^AW words.
- `SAT`, 0: 1 = signed saturating accumulate, 0 = wrap modulo 2^DW.

Ports:
- `clk`  in  1  single clock, all logic on rising edge.
- `reset`  in  1  asynchronous, active-high.
- `h_wr`  in  1  host write strobe.
- `h_rd`  in  1  host read strobe.
- `h_addr`  in  AW  host address, shared by read and write.
- `h_wdata`  in  DW  host write data.
- `h_rdata`  out  DW  host read data, registered.
- `h_rvalid`  out  1  `h_rdata` valid.
- `c_rd`  in  1  core read strobe.
- `c_raddr`  in  AW  core read address.
- `c_rdata`  out  DW  core read data, registered.
- `c_rvalid`  out  1  `c_rdata` valid.
- `c_wr`  in  1  core write strobe.
- `c_acc`  in  1  qualifies `c_wr`: 1 = accumulate into the stored word, 0 = overwrite.
- `c_waddr`  in  AW  core write address.
- `c_wdata`  in  DW  core write data.
- `swap`  in  1  bank exchange pulse.
- `host_bank`  out  1  index of the bank currently owned by the host.

## Operation
- Ownership:
  - `host_bank` = 0 → host owns bank 0 and core owns bank 1; otherwise reversed.
  - `swap` toggles `host_bank` at the clock edge.
  - All host and core requests in the swap cycle use the pre-swap mapping.
- Host port:
  - `h_wr` writes `h_wdata` directly.
  - `h_rd` reads the host bank.
  - `h_wr` and `h_rd` in the same cycle to the same address: read returns the old data.
- Core read: `c_rd` reads the core bank, with forwarding from the write stage (see below).
- Core write stage:
  - A `c_wr` request is captured into stage registers: valid, bank tag = current core bank, address, data, acc.
  - For accumulate, the operand is taken from the core bank, or forwarded from the stage if the stage holds a valid write to the same bank and address. This makes back-to-back accumulates to one address chain correctly.
  - The commit cycle writes `old + c_wdata` (acc) or `c_wdata` (overwrite) into the tagged bank.
  - A commit still lands in its tagged bank after a swap.
- Arithmetic:
  - `SAT`=0: DW-bit two's-complement wrap.
  - `SAT`=1: clamp to 2^(DW-1)-1 or -2^(DW-1).
- Forwarding to core reads: a `c_rd` whose address matches a committing write to the current core bank returns the committed value.
- Reset:
  - `host_bank`, `h_rvalid`, `c_rvalid`, and the stage valid go to 0.
  - `h_rdata` and `c_rdata` go to 0.
  - Memory contents are not reset.
  - A reset asserted mid-operation drops any pending commit.

## Timing
- Host read: `h_rd` in cycle N → `h_rdata` and `h_rvalid` in cycle N+1. `h_rvalid` is high for exactly one cycle per strobe, and `h_rdata` holds its value otherwise.
- Host write: visible to a host read issued in cycle N+1.
- Core read: `c_rd` in cycle N → `c_rdata` and `c_rvalid` in cycle N+1.
- Core write:
  - `c_wr` in cycle N → stage valid in cycle N+1 → memory updated at the end of cycle N+1.
  - A `c_rd` in cycle N+1 to that address sees the new value; one in cycle N sees the old value.
- Throughput: one host op and one core read plus one core write per cycle, with no stalls.

## Structure
- Package `dnn_buf_pkg`:
  - `sat_add` function parametrised by DW.
  - Bank-index typedef.
- Sub-module `dnn_buf_bank`: one 2^AW×DW array with a write port, a registered read port and a combinational RMW read port. It is instantiated twice.
- Top level: `host_bank` flip-flop, write stage, forwarding muxes, output registers.

## Test plan
- Reset, then `h_wr` 0x11 to address 5, then `h_rd` address 5 → `h_rdata`=0x11 with `h_rvalid` one cycle later; `host_bank`=0.
- Swap, then `c_rd` address 5 → 0x11; `c_wr` acc 0x22 to address 5 for three consecutive cycles → `c_rd` returns 0x77.
- `c_wr` overwrite 0x5 to address 3 in cycle N, `c_rd` address 3 in cycle N+1 → 0x5 (forwarding); `c_rd` in cycle N → old value.
- `SAT`=1, DW=16: address holds 0x7FF0, acc 0x0100 → 0x7FFF; with `SAT`=0 → 0x80F0.
- `c_wr` in the swap cycle → data lands in the old core bank; a host read of that address after the swap returns it.
- Assert `reset` while the write stage is valid → the write is dropped and all outputs read 0 next cycle.
